alu_cmd_sequencer: RTL and testbench

Command-side front end for the ALU result multiplexer. Accepts ALU commands (opcode, operands, tag) over a valid/ready channel, drives the 4-bit function select and operands into the combinational ALU datapath, registers the selected result with N/Z/C/V flags, and returns it over a valid/ready response channel. It generates the select code that the multiplexer consumes.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_cmd_sequencer_if.sv | 31 +++
 rtl/alu_flag_gen.sv | 41 ++++
 rtl/alu_cmd_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OpSum  = 4'd0,
    OpSubs = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpNot  = 4'd4,
    OpXor  = 4'd5,
    OpSll  = 4'd6,
    OpSla  = 4'd7,
    OpSrl  = 4'd8,
    OpSra  = 4'd9,
    OpF10  = 4'd10,
    OpF11  = 4'd11,
    OpF12  = 4'd12,
    OpF13  = 4'd13,
    OpF14  = 4'd14,
    OpF15  = 4'd15
  } alu_op_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } seq_state_e;

  function automatic logic is_reserved(alu_op_e op);
    return op >= OpF10;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready channels between a requester and the ALU command sequencer.
interface alu_cmd_sequencer_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned TAG_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [N-1:0]     cmd_a;
  logic [N-1:0]     cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_result;
  logic [3:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational {N,Z,C,V} generation from the executed op, its operands and the ALU result.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  alu_op_e      op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] result_i,
  output logic [3:0]   flags_o
);

  logic [N:0] sum;
  logic [N:0] diff;

  // Widened by one bit so the top bit is carry-out / borrow.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_N] = result_i[N-1];
    flags_o[FLAG_Z] = (result_i == '0);
    case (op_i)
      OpSum: begin
        flags_o[FLAG_C] = sum[N];
        flags_o[FLAG_V] = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      OpSubs: begin
        flags_o[FLAG_C] = ~diff[N];
        flags_o[FLAG_V] = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);
      end
      default: begin
        flags_o[FLAG_C] = 1'b0;
        flags_o[FLAG_V] = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequences one ALU command at a time: latch, drive the ALU for one cycle, hold the response.
// Define ALU_RESERVED_TRAP_EN to trap ops 10-15 with rsp_err set and zero result/flags.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_cmd_sequencer_if.slave   cmd_bus,
  output logic [3:0]           alu_sel_o,
  output logic [N-1:0]         alu_a_o,
  output logic [N-1:0]         alu_b_o,
  input  logic [N-1:0]         alu_result_i
);

  seq_state_e       state_q, state_d;
  alu_op_e          op_q;
  logic [N-1:0]     a_q, b_q;
  logic [TAG_W-1:0] tag_q;

  logic [N-1:0]     rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;

  logic             latch_en, capture_en, cmd_ready, rsp_valid;
  logic [3:0]       flags_gen;
  logic [N-1:0]     result_c;
  logic [3:0]       flags_c;
  logic             err_c;

  alu_flag_gen #(
    .N (N)
  ) u_flag_gen (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_i (alu_result_i),
    .flags_o  (flags_gen)
  );

`ifdef ALU_RESERVED_TRAP_EN
  always_comb begin
    err_c    = is_reserved(op_q);
    result_c = err_c ? '0 : alu_result_i;
    flags_c  = err_c ? '0 : flags_gen;
  end
`else
  always_comb begin
    err_c    = 1'b0;
    result_c = alu_result_i;
    flags_c  = flags_gen;
  end
`endif

  always_comb begin
    state_d    = state_q;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_bus.cmd_valid) begin
          latch_en = 1'b1;
          state_d  = StExec;
        end
      end
      StExec: begin
        capture_en = 1'b1;
        state_d    = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (cmd_bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      op_q         <= OpSum;
      a_q          <= '0;
      b_q          <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        op_q  <= alu_op_e'(cmd_bus.cmd_op);
        a_q   <= cmd_bus.cmd_a;
        b_q   <= cmd_bus.cmd_b;
        tag_q <= cmd_bus.cmd_tag;
      end
      if (capture_en) begin
        rsp_result_q <= result_c;
        rsp_flags_q  <= flags_c;
        rsp_tag_q    <= tag_q;
        rsp_err_q    <= err_c;
      end
    end
  end

  // Handshake outputs are forced low while reset is asserted, whatever the state register holds.
  assign cmd_bus.cmd_ready  = cmd_ready & ~rst_i;
  assign cmd_bus.rsp_valid  = rsp_valid & ~rst_i;
  assign cmd_bus.rsp_result = rsp_result_q;
  assign cmd_bus.rsp_flags  = rsp_flags_q;
  assign cmd_bus.rsp_tag    = rsp_tag_q;
  assign cmd_bus.rsp_err    = rsp_err_q;

  assign alu_sel_o = op_q;
  assign alu_a_o   = a_q;
  assign alu_b_o   = b_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer; a local reference ALU supplies alu_result_i.
module tb_alu_cmd_sequencer;

  localparam int unsigned N     = 32;
  localparam int unsigned TAG_W = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   alu_sel;
  logic [N-1:0] alu_a, alu_b, alu_result;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_prev = 0;

  alu_cmd_sequencer_if #(.N(N), .TAG_W(TAG_W)) bus ();

  alu_cmd_sequencer #(
    .N     (N),
    .TAG_W (TAG_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_bus      (bus),
    .alu_sel_o    (alu_sel),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_result_i (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU datapath; F10-F15 return a recognisable pattern carrying the select.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = ~alu_a;
      4'd5:    alu_result = alu_a ^ alu_b;
      4'd6:    alu_result = alu_a << alu_b[4:0];
      4'd7:    alu_result = alu_a << alu_b[4:0];
      4'd8:    alu_result = alu_a >> alu_b[4:0];
      4'd9:    alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = {28'hA5A5A5A, alu_sel};
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [TAG_W-1:0] tag);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_tag   = tag;
  endtask

  task automatic check_rsp(input string nm, input logic [N-1:0] res, input logic [3:0] flg,
                           input logic [TAG_W-1:0] tag, input logic err);
    check({nm, "_valid"}, 64'(bus.rsp_valid), 64'(1'b1));
    check({nm, "_result"}, 64'(bus.rsp_result), 64'(res));
    check({nm, "_flags"}, 64'(bus.rsp_flags), 64'(flg));
    check({nm, "_tag"}, 64'(bus.rsp_tag), 64'(tag));
    check({nm, "_err"}, 64'(bus.rsp_err), 64'(err));
  endtask

  // One full command with rsp_ready low until the response is seen; ends back in IDLE.
  task automatic run_cmd(input string nm, input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [TAG_W-1:0] tag,
                         input logic [N-1:0] res, input logic [3:0] flg, input logic err);
    drive_cmd(op, a, b, tag);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check({nm, "_exec_sel"}, 64'(alu_sel), 64'(op));
    check({nm, "_exec_a"}, 64'(alu_a), 64'(a));
    check({nm, "_exec_cmd_ready"}, 64'(bus.cmd_ready), 64'(1'b0));
    check({nm, "_exec_rsp_valid"}, 64'(bus.rsp_valid), 64'(1'b0));
    @(negedge clk);
    check_rsp(nm, res, flg, tag, err);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({nm, "_done_valid"}, 64'(bus.rsp_valid), 64'(1'b0));
    check({nm, "_done_ready"}, 64'(bus.cmd_ready), 64'(1'b1));
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #1;
    check("rst_cmd_ready_pre", 64'(bus.cmd_ready), 64'(1'b0));
    @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1'b0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
    check("rst_result", 64'(bus.rsp_result), 64'(0));
    check("rst_flags", 64'(bus.rsp_flags), 64'(0));
    check("rst_tag", 64'(bus.rsp_tag), 64'(0));
    check("rst_err", 64'(bus.rsp_err), 64'(0));
    check("rst_sel", 64'(alu_sel), 64'(0));
    check("rst_a", 64'(alu_a), 64'(0));
    check("rst_b", 64'(alu_b), 64'(0));
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1'b1));

    // Sum with carry-out to zero: N0 Z1 C1 V0
    run_cmd("sum", 4'd0, 32'hFFFF_FFFF, 32'h1, 4'd5, 32'h0, 4'b0110, 1'b0);
    // Subtract with signed overflow: N0 Z0 C1 V1
    run_cmd("subs", 4'd1, 32'h8000_0000, 32'h1, 4'd6, 32'h7FFF_FFFF, 4'b0011, 1'b0);

    // Backpressure: response held 4 cycles while a second command waits
    drive_cmd(4'd5, 32'h0000_F0F0, 32'h0000_0FF0, 4'd9);
    @(negedge clk);
    drive_cmd(4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd7);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_rsp("bp_hold", 32'h0000_FF00, 4'b0000, 4'd9, 1'b0);
      check("bp_cmd_ready", 64'(bus.cmd_ready), 64'(1'b0));
      check("bp_sel_held", 64'(alu_sel), 64'(4'd5));
      @(negedge clk);
    end
    check_rsp("bp_last", 32'h0000_FF00, 4'b0000, 4'd9, 1'b0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_hs_valid", 64'(bus.rsp_valid), 64'(1'b0));
    check("bp_hs_cmd_ready", 64'(bus.cmd_ready), 64'(1'b1));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("bp2_exec_sel", 64'(alu_sel), 64'(4'd2));
    check("bp2_cmd_ready", 64'(bus.cmd_ready), 64'(1'b0));
    @(negedge clk);
    check_rsp("bp2", 32'h0F00_0F00, 4'b0000, 4'd7, 1'b0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);

    // Back-to-back with rsp_ready held high: responses 3 cycles apart
    for (int i = 0; i < 3; i++) begin
      logic [3:0]   op;
      logic [N-1:0] a, b, res;
      logic [3:0]   flg;
      case (i)
        0:       begin op = 4'd3; a = 32'h1234;      b = 32'h00FF; res = 32'h12FF;      flg = 4'b0000; end
        1:       begin op = 4'd4; a = 32'h0;         b = 32'h0;    res = 32'hFFFF_FFFF; flg = 4'b1000; end
        default: begin op = 4'd9; a = 32'h8000_0000; b = 32'h4;    res = 32'hF800_0000; flg = 4'b1000; end
      endcase
      drive_cmd(op, a, b, 4'(i + 1));
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("b2b_exec_cmd_ready", 64'(bus.cmd_ready), 64'(1'b0));
      @(negedge clk);
      check_rsp("b2b", res, flg, 4'(i + 1), 1'b0);
      if (i > 0) check("b2b_spacing", 64'(cyc - t_prev), 64'(3));
      t_prev = cyc;
      @(negedge clk);
      check("b2b_one_cycle", 64'(bus.rsp_valid), 64'(1'b0));
    end
    bus.rsp_ready = 1'b0;

    // Reserved op 12
`ifdef ALU_RESERVED_TRAP_EN
    run_cmd("rsvd", 4'd12, 32'h3, 32'h4, 4'd11, 32'h0, 4'b0000, 1'b1);
`else
    run_cmd("rsvd", 4'd12, 32'h3, 32'h4, 4'd11, 32'hA5A5_A5AC, 4'b1000, 1'b0);
`endif

    // Reset during EXEC discards the command
    drive_cmd(4'd0, 32'h1, 32'h2, 4'd3);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1'b0));
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
    rst = 1'b0;
    #1;
    check("after_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1'b1));
    check("after_rst_sel", 64'(alu_sel), 64'(0));
    check("after_rst_result", 64'(bus.rsp_result), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after_rst_no_rsp", 64'(bus.rsp_valid), 64'(1'b0));
      check("after_rst_idle", 64'(bus.cmd_ready), 64'(1'b1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
